// File: rtl/clock_supervisor.sv
// Clock supervisor: qualifies the PLL lock and releases a downstream reset only after the lock has
// been held continuously for STABLE_CYCLES cycles. While released, it generates fractional
// clock-enable strobes with one phase accumulator per channel, and it counts lock losses.
module clock_supervisor #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned ACC_W         = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_W        = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      pll_locked,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic                      run,
    output logic                      rst_out_n,
    output logic [CHANNELS-1:0]       ce,
    output logic [1:0]                state,
    output logic [LOSS_W-1:0]         loss_count
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock  = 2'd0,
        StStabilise = 2'd1,
        StRun       = 2'd2,
        StLost      = 2'd3
    } state_e;

    state_e            state_q;
    logic              sync1_q;
    logic              lock_s;
    logic [CNT_W-1:0]  stable_q;
    logic [LOSS_W-1:0] loss_q;
    logic [ACC_W-1:0]  acc_q [CHANNELS];
    logic [CHANNELS-1:0] ce_q;
    logic [ACC_W:0]    sum [CHANNELS];
    logic              accum_en;

    // Lock synchroniser, lock-qualification FSM, stable counter and saturating loss counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            lock_s   <= 1'b0;
            state_q  <= StWaitLock;
            stable_q <= '0;
            loss_q   <= '0;
        end else begin
            sync1_q <= pll_locked;
            lock_s  <= sync1_q;
            case (state_q)
                StWaitLock: begin
                    stable_q <= '0;
                    if (lock_s) begin
                        state_q <= StStabilise;
                    end
                end
                StStabilise: begin
                    if (!lock_s) begin
                        state_q  <= StWaitLock;
                        stable_q <= '0;
                    end else if (stable_q == CntLast) begin
                        state_q  <= StRun;
                        stable_q <= '0;
                    end else begin
                        stable_q <= stable_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_q <= StLost;
                        if (loss_q != '1) begin
                            loss_q <= loss_q + LOSS_W'(1);
                        end
                    end
                end
                default: begin
                    // Lost lasts exactly one cycle
                    state_q  <= StWaitLock;
                    stable_q <= '0;
                end
            endcase
        end
    end

    // Accumulation happens only while released and still locked; a lock loss wins over run
    always_comb begin
        accum_en = (state_q == StRun) && lock_s;
        for (int k = 0; k < CHANNELS; k++) begin
            sum[k] = {1'b0, acc_q[k]} + {1'b0, inc[k*ACC_W +: ACC_W]};
        end
    end

    // Phase accumulators: carry out becomes the registered strobe
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc_q[k] <= '0;
            end
            ce_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (accum_en) begin
                    if (run) begin
                        acc_q[k] <= sum[k][ACC_W-1:0];
                        ce_q[k]  <= sum[k][ACC_W];
                    end else begin
                        // Hold phase so resuming continues the same strobe spacing
                        ce_q[k] <= 1'b0;
                    end
                end else begin
                    acc_q[k] <= '0;
                    ce_q[k]  <= 1'b0;
                end
            end
        end
    end

    assign rst_out_n  = (state_q == StRun);
    assign ce         = ce_q;
    assign state      = state_q;
    assign loss_count = loss_q;

endmodule

// File: doc/clock_supervisor.md
CLOCK_SUPERVISOR -- requirements
Module: clock_supervisor

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of clock-enable outputs (1..8).
REQ-002 SHALL have parameter ACC_W, default 16, phase-accumulator and increment width per channel.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, cycles of continuous lock required before release (>=2).
REQ-004 SHALL have parameter LOSS_W, default 8, width of lock-loss counter.
REQ-005 SHALL have port clock  in  1  system clock (PLL CLKOP, 125 MHz nominal); all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port pll_locked  in  1  PLL LOCK, asynchronous to clock.
REQ-008 SHALL have port inc  in  CHANNELS*ACC_W  per-channel phase increment; channel k at bits [k*ACC_W +: ACC_W].
REQ-009 SHALL have port run  in  1  enables clock-enable generation while released.
REQ-010 SHALL have port rst_out_n  out  1  downstream synchronous reset, active-low.
REQ-011 SHALL have port ce  out  CHANNELS  single-cycle clock-enable strobes.
REQ-012 SHALL have port state  out  2  current FSM state encoding.
REQ-013 SHALL have port loss_count  out  LOSS_W  saturating count of lock losses.

Function
REQ-014 SHALL synchronise pll_locked through two flops; lock_s is the second flop output; no other logic SHALL use pll_locked directly.
REQ-015 SHALL implement FSM WAIT_LOCK=0, STABILISE=1, RUN=2, LOST=3, registered, driven onto state.
REQ-016 WAIT_LOCK: stable counter held at 0; lock_s=1 -> STABILISE next edge.
REQ-017 STABILISE: counter increments each cycle; lock_s=0 -> WAIT_LOCK with counter cleared; counter==STABLE_CYCLES-1 with lock_s=1 -> RUN; STABILISE therefore lasts exactly STABLE_CYCLES cycles.
REQ-018 RUN: lock_s=0 -> LOST on next edge, loss_count incremented on same edge, saturating at all-ones.
REQ-019 LOST: lasts exactly one cycle, then WAIT_LOCK unconditionally.
REQ-020 rst_out_n SHALL be 1 iff state==RUN, decoded directly from the state register (no extra delay).
REQ-021 Per channel SHALL hold ACC_W-bit accumulator acc[k]; in RUN with run=1 each edge computes {carry,acc[k]} = acc[k]+inc[k] (ACC_W+1-bit sum), acc[k] takes low ACC_W bits, ce[k] registered = carry.
REQ-022 Strobe rate SHALL be f_clock*inc[k]/2^ACC_W; inc[k]=0 SHALL never assert ce[k]; each ce pulse SHALL last one cycle.
REQ-023 In RUN with run=0: acc held, ce=0 on next edge; resuming continues from held phase.
REQ-024 Outside RUN (including the edge entering LOST): all acc cleared to 0, ce=0 on next edge.
REQ-025 Changes to inc SHALL take effect on the next accumulation edge; no glitch or double strobe beyond REQ-021 arithmetic.
REQ-026 Simultaneous lock_s=0 and run toggle in RUN: lock loss takes priority, ce=0 next edge.

Reset
REQ-027 reset_n=0 at an edge SHALL force: sync flops 0, state WAIT_LOCK, stable counter 0, all acc 0, ce 0, loss_count 0, rst_out_n 0.
REQ-028 Reset SHALL override every FSM state, including mid-STABILISE and RUN; loss_count SHALL NOT increment due to reset.
REQ-029 After reset release, behaviour SHALL follow REQ-016 onward with no additional delay.

Verification
REQ-030 Lock acquire: STABLE_CYCLES=16, pll_locked rises and stays -> state 1 two edges after sampling, rst_out_n rises exactly 16 cycles later, state=2.
REQ-031 Glitch: pll_locked drops for 3 cycles at STABILISE count 10 -> return to WAIT_LOCK, full 16-cycle count restarts, loss_count stays 0.
REQ-032 Ratios: ACC_W=16, run=1, inc0=16384, inc1=32768 -> ce[0] every 4th cycle, ce[1] every 2nd; inc0=27307 -> 5 strobes per 12 cycles +/-1 over 1200 cycles (52.08 MHz at 125 MHz).
REQ-033 Lock loss in RUN: pll_locked low -> LOST for one cycle, rst_out_n 0, ce 0, acc cleared, loss_count 0->1; LOSS_W=2 with 5 losses -> loss_count=3.
REQ-034 run gating: run=0 for 7 cycles mid-stream -> no ce; run=1 -> strobe spacing continues from held phase.
REQ-035 Reset in RUN with ce pulsing: reset_n=0 one edge -> all outputs at REQ-027 values next cycle, loss_count 0.
